// File: rtl/kyber_ram_pkg.sv
// Shared mode encodings, width helpers and default latencies for the polynomial RAM.
package kyber_ram_pkg;

  typedef enum logic [2:0] {
    MODE_PWRITE = 3'b000,
    MODE_NTT    = 3'b001,
    MODE_PWM    = 3'b010,
    MODE_INTT   = 3'b100,
    MODE_PWA    = 3'b110
  } mode_e;

  localparam int unsigned DEF_LAT_NTT = 7;
  localparam int unsigned DEF_LAT_PW  = 10;

  // Bank-index width; at least one bit so a single-bank build still elaborates.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Latency field width: must hold the value max_lat itself.
  function automatic int unsigned lat_width(input int unsigned max_lat);
    return $clog2(max_lat + 1);
  endfunction

  function automatic logic is_ntt_mode(input logic [2:0] m);
    return (m == MODE_NTT) || (m == MODE_INTT);
  endfunction

endpackage

// File: rtl/wb_delay_line.sv
// Shift register of write-back descriptors with valid bits and a runtime tap.
// Stage k (1-based) holds an entry during the k-th cycle after it was pushed.
// An entry reaching the tap is consumed there and never moves further down.
module wb_delay_line #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             flush,
  input  logic [TW-1:0]    tap,
  output logic             tap_valid,
  output logic [WIDTH-1:0] tap_data,
  output logic             any_valid
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // Valid bits: shift by one stage, dropping the entry that sits at the tap.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= push;
      for (int k = 1; k < int'(DEPTH); k++) begin
        valid_q[k] <= valid_q[k-1] && (k != int'(tap));
      end
    end
  end

  // Payload shifts unconditionally; only the valid bits carry meaning.
  always_ff @(posedge clk) begin
    data_q[0] <= push_data;
    for (int k = 1; k < int'(DEPTH); k++) begin
      data_q[k] <= data_q[k-1];
    end
  end

  // Tap select: tap value t addresses stage t (array index t-1).
  always_comb begin
    tap_valid = 1'b0;
    tap_data  = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if ((k + 1) == int'(tap)) begin
        tap_valid = valid_q[k];
        tap_data  = data_q[k];
      end
    end
  end

  assign any_valid = |valid_q;

endmodule

// File: rtl/poly_ram_nbank.sv
// N-bank polynomial RAM with per-port crossbar, programmable write-back latency,
// conflict and illegal-mode-change detection.
module poly_ram_nbank
  import kyber_ram_pkg::*;
#(
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned MAX_LAT     = 16,
  parameter int unsigned LAT_NTT_DEF = DEF_LAT_NTT,
  parameter int unsigned LAT_PW_DEF  = DEF_LAT_PW,
  localparam int unsigned IW = idx_width(NUM_BANKS),
  localparam int unsigned LW = lat_width(MAX_LAT)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [2:0]                      mode,
  input  logic                            cfg_we,
  input  logic [LW-1:0]                   cfg_lat_ntt,
  input  logic [LW-1:0]                   cfg_lat_pw,
  input  logic                            rd_en,
  input  logic                            wen,
  input  logic [NUM_BANKS*IW-1:0]         bank_idx,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] din,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] dout,
  output logic                            dout_valid,
  output logic                            wb_pending,
  output logic                            cfg_reject,
  output logic                            conflict_err,
  output logic                            mode_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned PW    = NUM_BANKS * (ADDR_WIDTH + IW);

  logic [NUM_BANKS-1:0][IW-1:0]         port_idx;
  logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0] port_addr;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] port_din;

  assign port_idx  = bank_idx;
  assign port_addr = addr;
  assign port_din  = din;

  logic [2:0]    mode_q;
  logic [LW-1:0] lat_ntt_q, lat_pw_q, tap;
  logic          cfg_reject_q, conflict_q, mode_err_q;
  logic          pwrite_mode, flush, push, dup, cfg_ok;

  logic [NUM_BANKS-1:0]                 bank_hit;
  logic [NUM_BANKS-1:0][IW-1:0]         bank_port;
  logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0] bank_addr;

  logic                                 tap_valid;
  logic [PW-1:0]                        tap_data;
  logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0] wb_addr;
  logic [NUM_BANKS-1:0][IW-1:0]         wb_idx;

  logic [NUM_BANKS-1:0]                 bank_we;
  logic [NUM_BANKS-1:0][ADDR_WIDTH-1:0] bank_waddr;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_wdata;

  logic [DATA_WIDTH-1:0]                mem [NUM_BANKS][DEPTH];
  logic                                 rd_q, dout_valid_q;
  logic [NUM_BANKS-1:0][IW-1:0]         idx_q;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] rdata_q, dout_q;

  function automatic logic [LW-1:0] clamp_lat(input logic [LW-1:0] v);
    if ((v == '0) || (32'(v) > MAX_LAT)) return LW'(MAX_LAT);
    return v;
  endfunction

  assign pwrite_mode = (mode_q == MODE_PWRITE);
  assign flush       = (mode != mode_q) && wb_pending;
  assign push        = rd_en && !pwrite_mode;
  assign tap         = is_ntt_mode(mode_q) ? lat_ntt_q : lat_pw_q;
  assign cfg_ok      = !wb_pending && !rd_en;

  // Input crossbar: each bank takes the lowest-index port that targets it.
  always_comb begin
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      bank_hit[b]  = 1'b0;
      bank_port[b] = '0;
      bank_addr[b] = '0;
      for (int p = int'(NUM_BANKS) - 1; p >= 0; p--) begin
        if (port_idx[p] == IW'(b)) begin
          bank_hit[b]  = 1'b1;
          bank_port[b] = IW'(p);
          bank_addr[b] = port_addr[p];
        end
      end
    end
  end

  // Any two ports naming the same bank is a conflict.
  always_comb begin
    dup = 1'b0;
    for (int p = 0; p < int'(NUM_BANKS); p++) begin
      for (int q = p + 1; q < int'(NUM_BANKS); q++) begin
        if (port_idx[p] == port_idx[q]) dup = 1'b1;
      end
    end
  end

  wb_delay_line #(
    .DEPTH (MAX_LAT),
    .WIDTH (PW),
    .TW    (LW)
  ) u_wb_delay_line (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({bank_addr, port_idx}),
    .flush     (flush),
    .tap       (tap),
    .tap_valid (tap_valid),
    .tap_data  (tap_data),
    .any_valid (wb_pending)
  );

  assign {wb_addr, wb_idx} = tap_data;

  // Write select: direct writes in pwrite, tap-aligned write-back otherwise.
  always_comb begin
    bank_we    = '0;
    bank_waddr = '0;
    bank_wdata = '0;
    if (pwrite_mode) begin
      if (wen) begin
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
          bank_we[b]    = bank_hit[b];
          bank_waddr[b] = bank_addr[b];
          bank_wdata[b] = port_din[bank_port[b]];
        end
      end
    end else if (wen && tap_valid && !flush) begin
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
        for (int p = int'(NUM_BANKS) - 1; p >= 0; p--) begin
          if (wb_idx[p] == IW'(b)) begin
            bank_we[b]    = 1'b1;
            bank_waddr[b] = wb_addr[b];
            bank_wdata[b] = port_din[p];
          end
        end
      end
    end
  end

  // Bank storage: no reset so contents survive rst; writes blocked while in reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      if (rst && bank_we[b]) mem[b][bank_waddr[b]] <= bank_wdata[b];
    end
  end

  // Synchronous read-first bank read plus one-cycle delayed routing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q    <= 1'b0;
      idx_q   <= '0;
      rdata_q <= '0;
    end else begin
      rd_q <= rd_en;
      if (rd_en) begin
        idx_q <= port_idx;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
          rdata_q[b] <= mem[b][bank_addr[b]];
        end
      end
    end
  end

  // Registered output crossbar back into port order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      dout_valid_q <= rd_q;
      if (rd_q) begin
        for (int p = 0; p < int'(NUM_BANKS); p++) begin
          dout_q[p] <= rdata_q[idx_q[p]];
        end
      end
    end
  end

  // Mode register, latency configuration and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q       <= MODE_PWRITE;
      lat_ntt_q    <= LW'(LAT_NTT_DEF);
      lat_pw_q     <= LW'(LAT_PW_DEF);
      cfg_reject_q <= 1'b0;
      conflict_q   <= 1'b0;
      mode_err_q   <= 1'b0;
    end else begin
      mode_q       <= mode;
      cfg_reject_q <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) begin
        lat_ntt_q <= clamp_lat(cfg_lat_ntt);
        lat_pw_q  <= clamp_lat(cfg_lat_pw);
      end
      if (dup && (rd_en || (wen && pwrite_mode))) conflict_q <= 1'b1;
      if (flush) mode_err_q <= 1'b1;
    end
  end

  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;
  assign cfg_reject   = cfg_reject_q;
  assign conflict_err = conflict_q;
  assign mode_err     = mode_err_q;

endmodule

// File: tb/tb_poly_ram_nbank.sv
// Randomised and directed bench for poly_ram_nbank against a transaction-level model.
module tb_poly_ram_nbank;

  localparam int NB = 4;
  localparam int AW = 5;
  localparam int DW = 24;
  localparam int IW = 2;
  localparam int LW = 5;
  localparam int MAXL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, cfg_we, rd_en, wen;
  logic [2:0]             mode;
  logic [LW-1:0]          cfg_lat_ntt, cfg_lat_pw;
  logic [NB-1:0][IW-1:0]  idx;
  logic [NB-1:0][AW-1:0]  addr;
  logic [NB-1:0][DW-1:0]  din, dout;
  logic                   dout_valid, wb_pending, cfg_reject, conflict_err, mode_err;

  poly_ram_nbank dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .cfg_we       (cfg_we),
    .cfg_lat_ntt  (cfg_lat_ntt),
    .cfg_lat_pw   (cfg_lat_pw),
    .rd_en        (rd_en),
    .wen          (wen),
    .bank_idx     (idx),
    .addr         (addr),
    .din          (din),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .wb_pending   (wb_pending),
    .cfg_reject   (cfg_reject),
    .conflict_err (conflict_err),
    .mode_err     (mode_err)
  );

  // Reference model: memory image, pending write-backs keyed by due cycle,
  // pending read results keyed by the cycle they must appear.
  typedef struct packed {
    logic [31:0]           due;
    logic [NB-1:0][IW-1:0] idx;
    logic [NB-1:0][AW-1:0] ta;
  } wb_t;

  typedef struct packed {
    logic [31:0]           due;
    logic [NB-1:0][DW-1:0] d;
  } rd_t;

  logic [DW-1:0] mem_m [NB][2**AW];
  wb_t           wbq[$];
  rd_t           rdq[$];
  logic [2:0]    mode_m;
  int            lat_ntt_m, lat_pw_m;
  bit            conf_m, merr_m, rej_m;
  int unsigned   cyc;
  int            n_checks = 0;
  int            n_err = 0;
  logic [2:0]    modes [5];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int clamp(input logic [LW-1:0] v);
    if (v == 0 || int'(v) > MAXL) return MAXL;
    return int'(v);
  endfunction

  task automatic model_reset();
    wbq.delete();
    rdq.delete();
    mode_m    = 3'b000;
    lat_ntt_m = 7;
    lat_pw_m  = 10;
    conf_m    = 1'b0;
    merr_m    = 1'b0;
    rej_m     = 1'b0;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model with this cycle's inputs.
  task automatic cycle();
    rd_t                   r;
    wb_t                   e, ne;
    logic [NB-1:0][AW-1:0] ta;
    int                    win [NB];
    bit                    claimed [NB];
    bit                    pend, flush, dup;
    int                    lat;
    @(negedge clk);
    check_eq("wb_pending", wb_pending, wbq.size() > 0);
    check_eq("cfg_reject", cfg_reject, rej_m);
    check_eq("conflict_err", conflict_err, conf_m);
    check_eq("mode_err", mode_err, merr_m);
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      r = rdq.pop_front();
      check_eq("dout_valid", dout_valid, 1'b1);
      for (int p = 0; p < NB; p++) check_eq($sformatf("dout[%0d]", p), dout[p], r.d[p]);
    end else begin
      check_eq("dout_valid", dout_valid, 1'b0);
    end
    if (!rst) begin
      model_reset();
    end else begin
      for (int b = 0; b < NB; b++) win[b] = -1;
      for (int p = 0; p < NB; p++) if (win[idx[p]] < 0) win[idx[p]] = p;
      dup = 1'b0;
      for (int p = 0; p < NB; p++) begin
        ta[p] = addr[win[idx[p]]];
        if (win[idx[p]] != p) dup = 1'b1;
      end
      pend  = (wbq.size() > 0);
      flush = (mode != mode_m) && pend;
      lat   = (mode_m == 3'b001 || mode_m == 3'b100) ? lat_ntt_m : lat_pw_m;
      if (rd_en) begin
        r.due = cyc + 2;
        for (int p = 0; p < NB; p++) r.d[p] = mem_m[idx[p]][ta[p]];
        rdq.push_back(r);
      end
      if (dup && (rd_en || (wen && mode_m == 3'b000))) conf_m = 1'b1;
      if (mode_m == 3'b000 && wen) begin
        for (int p = 0; p < NB; p++) if (win[idx[p]] == p) mem_m[idx[p]][addr[p]] = din[p];
      end
      if (pend && wbq[0].due == cyc) begin
        e = wbq.pop_front();
        if (mode_m != 3'b000 && wen && !flush) begin
          for (int b = 0; b < NB; b++) claimed[b] = 1'b0;
          for (int p = 0; p < NB; p++) begin
            if (!claimed[e.idx[p]]) begin
              mem_m[e.idx[p]][e.ta[p]] = din[p];
              claimed[e.idx[p]] = 1'b1;
            end
          end
        end
      end
      if (rd_en && mode_m != 3'b000) begin
        ne.due = cyc + lat;
        ne.idx = idx;
        ne.ta  = ta;
        wbq.push_back(ne);
      end
      if (flush) begin
        wbq.delete();
        merr_m = 1'b1;
      end
      rej_m = cfg_we && (pend || rd_en);
      if (cfg_we && !pend && !rd_en) begin
        lat_ntt_m = clamp(cfg_lat_ntt);
        lat_pw_m  = clamp(cfg_lat_pw);
      end
      mode_m = mode;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    rd_en  = 1'b0;
    wen    = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic perm_idx(input int k);
    for (int p = 0; p < NB; p++) idx[p] = IW'(p ^ k);
  endtask

  // Read, wait for the tap, write a value back, then read the same words again.
  task automatic wb_trip(input int lat, input logic [DW-1:0] val);
    perm_idx($urandom_range(0, 3));
    for (int p = 0; p < NB; p++) addr[p] = AW'($urandom);
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    repeat (lat - 1) cycle();
    wen = 1'b1;
    for (int p = 0; p < NB; p++) din[p] = val + DW'(p);
    cycle();
    wen = 1'b0;
    cycle();
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    repeat (3) cycle();
  endtask

  initial begin
    modes[0] = 3'b000; modes[1] = 3'b001; modes[2] = 3'b010;
    modes[3] = 3'b100; modes[4] = 3'b110;
    rst = 1'b0; mode = 3'b000; cfg_lat_ntt = '0; cfg_lat_pw = '0;
    idle_inputs();
    idx = '0; addr = '0; din = '0;
    model_reset();
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 1'b1;

    // Fill every word of every bank with a known value.
    for (int a = 0; a < 2**AW; a++) begin
      wen = 1'b1;
      perm_idx(0);
      for (int p = 0; p < NB; p++) begin
        addr[p] = AW'(a);
        din[p]  = DW'($urandom);
      end
      cycle();
    end
    wen = 1'b0;

    // pwrite then read in NTT mode.
    for (int p = 0; p < NB; p++) begin
      idx[p]  = IW'(3 - p);
      addr[p] = AW'(5);
      din[p]  = DW'(13 - p);
    end
    wen = 1'b1;
    cycle();
    wen  = 1'b0;
    mode = 3'b001;
    cycle();
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    repeat (3) cycle();

    // NTT write-back at the default latency.
    wb_trip(7, 24'h000123);

    // Reprogram rejected while busy, then accepted when idle.
    perm_idx(1);
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    cfg_we = 1'b1; cfg_lat_pw = 5'd4; cfg_lat_ntt = 5'd7;
    cycle();
    cfg_we = 1'b0;
    repeat (8) cycle();
    cfg_we = 1'b1;
    cycle();
    cfg_we = 1'b0;
    mode = 3'b010;
    cycle();
    wb_trip(4, 24'h00ABC0);

    // Clamping of out-of-range latencies, then restore defaults.
    cfg_we = 1'b1; cfg_lat_ntt = 5'd0; cfg_lat_pw = 5'd31;
    cycle();
    cfg_we = 1'b0;
    mode = 3'b001;
    cycle();
    wb_trip(16, 24'h0F0F00);
    cfg_we = 1'b1; cfg_lat_ntt = 5'd7; cfg_lat_pw = 5'd10;
    cycle();
    cfg_we = 1'b0;

    // Conflict: ports 0 and 1 both on bank 1; flag must stay set while idle.
    idx[0] = 2'd1; idx[1] = 2'd1; idx[2] = 2'd2; idx[3] = 2'd3;
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    repeat (100) cycle();
    rst = 1'b0;
    cycle();
    rst  = 1'b1;
    mode = 3'b001;
    cycle();

    // Mode change two cycles after a read flushes the pending write-back.
    perm_idx(2);
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    cycle();
    mode = 3'b010;
    cycle();
    repeat (4) cycle();
    wen = 1'b1;
    for (int p = 0; p < NB; p++) din[p] = 24'hDEAD00;
    cycle();
    wen = 1'b0;
    repeat (12) cycle();
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    repeat (3) cycle();

    // Reset right after a read: nothing comes out, defaults are restored.
    mode = 3'b001;
    cycle();
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    repeat (3) cycle();
    wb_trip(7, 24'h007700);
    mode = 3'b010;
    cycle();
    wb_trip(10, 24'h001000);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 299) != 0);
      cfg_we      = ($urandom_range(0, 9) == 0);
      cfg_lat_ntt = LW'($urandom);
      cfg_lat_pw  = LW'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        mode  = modes[$urandom_range(0, 4)];
        rd_en = 1'b0;
        wen   = 1'b0;
      end else begin
        rd_en = ($urandom_range(0, 2) == 0);
        wen   = ($urandom_range(0, 1) == 0);
      end
      perm_idx($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        for (int p = 0; p < NB; p++) idx[p] = IW'($urandom);
      end
      for (int p = 0; p < NB; p++) begin
        addr[p] = AW'($urandom);
        din[p]  = DW'($urandom);
      end
      cycle();
    end
    idle_inputs();
    repeat (20) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
